// File: rtl/sid_spi_writer.sv
// SPI mode-0 master carrying SID register writes as {1,A[4:0],D[7:6]} then {0,0,D[5:0]}.
// Define SID_SPI_WRITER_FIFO_EN for a 4-entry request FIFO; otherwise a single holding register.
module sid_spi_writer #(
    parameter int CLK_DIV = 3,
    parameter int CS_GAP  = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       WR_VALID,
    output logic       WR_READY,
    input  logic [4:0] WR_ADDR,
    input  logic [7:0] WR_DATA,
    output logic       BUSY,
    output logic       SPI_SCK,
    output logic       SPI_MOSI,
    output logic       SPI_CS
);
    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_HOLD, S_GAP} state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [6:0]       sr_q, sr_n;
    logic [2:0]       bit_q, bit_n;
    logic [5:0]       lo_q, lo_n;
    logic             byte1_q, byte1_n;
    logic             sck_q, sck_n, mosi_q, mosi_n, cs_q, cs_n;
    logic             load0;

    logic             req_avail, req_pop, queued, push;
    logic [4:0]       req_addr;
    logic [7:0]       req_data;

    assign push = WR_VALID && WR_READY;

`ifdef SID_SPI_WRITER_FIFO_EN
    logic [4:0] f_addr [4];
    logic [7:0] f_data [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] f_cnt;
    logic       f_seen;

    assign WR_READY  = (f_cnt != 3'd4);
    // Head entry is only offered once it has sat in the FIFO for a cycle (registered read).
    assign req_avail = f_seen && (f_cnt != 3'd0);
    assign req_addr  = f_addr[rd_ptr];
    assign req_data  = f_data[rd_ptr];
    assign queued    = (f_cnt != 3'd0);

    always_ff @(posedge CLK) begin
        if (push) begin
            f_addr[wr_ptr] <= WR_ADDR;
            f_data[wr_ptr] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            f_cnt  <= '0;
            f_seen <= 1'b0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + 2'd1;
            if (req_pop) rd_ptr <= rd_ptr + 2'd1;
            f_cnt  <= f_cnt + {2'b00, push} - {2'b00, req_pop};
            f_seen <= (f_cnt != 3'd0);
        end
    end
`else
    logic       p_vld;
    logic [4:0] p_addr;
    logic [7:0] p_data;

    assign WR_READY  = (state_q == S_IDLE) && !p_vld;
    assign req_avail = p_vld;
    assign req_addr  = p_addr;
    assign req_data  = p_data;
    assign queued    = p_vld;

    always_ff @(posedge CLK) begin
        if (RST) begin
            p_vld  <= 1'b0;
            p_addr <= '0;
            p_data <= '0;
        end else if (push) begin
            p_vld  <= 1'b1;
            p_addr <= WR_ADDR;
            p_data <= WR_DATA;
        end else if (req_pop) begin
            p_vld  <= 1'b0;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            bit_q   <= '0;
            lo_q    <= '0;
            byte1_q <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b1;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            sr_q    <= sr_n;
            bit_q   <= bit_n;
            lo_q    <= lo_n;
            byte1_q <= byte1_n;
            sck_q   <= sck_n;
            mosi_q  <= mosi_n;
            cs_q    <= cs_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q + CNT_W'(1);
        sr_n    = sr_q;
        bit_n   = bit_q;
        lo_n    = lo_q;
        byte1_n = byte1_q;
        sck_n   = sck_q;
        mosi_n  = mosi_q;
        cs_n    = cs_q;
        req_pop = 1'b0;
        load0   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_n = '0;
                load0 = req_avail;
            end
            S_LOW: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_n   = '0;
                    sck_n   = 1'b1;
                    state_n = S_HIGH;
                end
            end
            S_HIGH: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_n = '0;
                    sck_n = 1'b0;
                    if (bit_q != 3'd0) begin
                        mosi_n  = sr_q[6];
                        sr_n    = {sr_q[5:0], 1'b0};
                        bit_n   = bit_q - 3'd1;
                        state_n = S_LOW;
                    end else begin
                        state_n = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_n   = '0;
                    cs_n    = 1'b1;
                    mosi_n  = 1'b0;
                    state_n = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(CS_GAP - 1)) begin
                    cnt_n = '0;
                    if (!byte1_q) begin
                        byte1_n = 1'b1;
                        sr_n    = {1'b0, lo_q};
                        mosi_n  = 1'b0;
                        bit_n   = 3'd7;
                        cs_n    = 1'b0;
                        state_n = S_LOW;
                    end else if (req_avail) begin
                        // Chain straight into the next request without an IDLE cycle.
                        load0 = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (load0) begin
            req_pop = 1'b1;
            mosi_n  = 1'b1;
            sr_n    = {req_addr, req_data[7:6]};
            lo_n    = req_data[5:0];
            bit_n   = 3'd7;
            byte1_n = 1'b0;
            cs_n    = 1'b0;
            sck_n   = 1'b0;
            cnt_n   = '0;
            state_n = S_LOW;
        end
    end

    assign SPI_SCK  = sck_q;
    assign SPI_MOSI = mosi_q;
    assign SPI_CS   = cs_q;
    assign BUSY     = (state_q != S_IDLE) || queued;
endmodule

// File: tb/tb_sid_spi_writer.sv
// Bench for sid_spi_writer: SPI bus monitor decodes bytes, compared against an encoding model.
module tb_sid_spi_writer;
    localparam int CLK_DIV = 3;
    localparam int CS_GAP  = 4;
    localparam int TXN_LEN = 2 * (17 * CLK_DIV + CS_GAP);
`ifdef SID_SPI_WRITER_FIFO_EN
    localparam int START_LAT = 2;
`else
    localparam int START_LAT = 1;
`endif

    logic       CLK = 1'b0;
    logic       RST, WR_VALID, WR_READY, BUSY, SPI_SCK, SPI_MOSI, SPI_CS;
    logic [4:0] WR_ADDR;
    logic [7:0] WR_DATA;

    sid_spi_writer #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .CLK(CLK), .RST(RST), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
        .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .BUSY(BUSY),
        .SPI_SCK(SPI_SCK), .SPI_MOSI(SPI_MOSI), .SPI_CS(SPI_CS)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    function automatic void check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Wire-format model: the two bytes a write must become.
    function automatic logic [7:0] enc0(input logic [4:0] a, input logic [7:0] d);
        return 8'h80 + 8'(a) * 8'd4 + d / 8'd64;
    endfunction
    function automatic logic [7:0] enc1(input logic [7:0] d);
        return d % 8'd64;
    endfunction

    always @(posedge CLK) cyc++;

    // Bus monitor: behaves as the receiving slave, sampling between edges.
    logic [7:0] rx_q[$];
    logic [7:0] shreg = '0;
    int         nbits = 0;
    int         cs_fall_cyc = 0, cs_rise_cyc = 0;
    logic       in_pair = 1'b0;
    logic       cs_prev = 1'b1, sck_prev = 1'b0, mosi_prev = 1'b0;

    always @(negedge CLK) begin
        if (cs_prev === 1'b1 && SPI_CS === 1'b0) begin
            check("sck_low_at_cs_fall", int'(SPI_SCK), 0);
            if (in_pair) check("cs_gap_len", cyc - cs_rise_cyc, CS_GAP);
            cs_fall_cyc = cyc;
            nbits = 0;
            shreg = '0;
        end
        if (cs_prev === 1'b0 && SPI_CS === 1'b1) begin
            check("sck_low_at_cs_rise", int'(SPI_SCK), 0);
            cs_rise_cyc = cyc;
            if (nbits == 8) begin
                check("cs_low_len", cyc - cs_fall_cyc, 17 * CLK_DIV);
                rx_q.push_back(shreg);
                in_pair = shreg[7];
            end else begin
                in_pair = 1'b0;
            end
        end
        if (SPI_CS === 1'b0 && sck_prev === 1'b0 && SPI_SCK === 1'b1) begin
            check("mosi_stable_at_sck_rise", int'(SPI_MOSI), int'(mosi_prev));
            shreg = {shreg[6:0], SPI_MOSI};
            nbits++;
        end
        cs_prev   = SPI_CS;
        sck_prev  = SPI_SCK;
        mosi_prev = SPI_MOSI;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [4:0] a, input logic [7:0] d);
        int n = 0;
        WR_VALID = 1'b1;
        WR_ADDR  = a;
        WR_DATA  = d;
        while (!WR_READY && n < 1000) begin step(); n++; end
        check("ready_within_bound", int'(n < 1000), 1);
        step();
        WR_VALID = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (BUSY && n < bound) begin step(); n++; end
        check("idle_within_bound", int'(n < bound), 1);
        step();
    endtask

    task automatic expect_write(input string tag, input logic [4:0] a, input logic [7:0] d);
        logic [7:0] b0, b1;
        check({tag, "_bytes_avail"}, int'(rx_q.size() >= 2), 1);
        if (rx_q.size() >= 2) begin
            b0 = rx_q.pop_front();
            b1 = rx_q.pop_front();
            check({tag, "_byte0"}, int'(b0), int'(enc0(a, d)));
            check({tag, "_byte1"}, int'(b1), int'(enc1(d)));
        end
    endtask

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
        logic [7:0] b0;
        logic [7:0] b1;
    } vec_t;
    vec_t vecs[4];

    logic [4:0] ea[$];
    logic [7:0] ed[$];

    initial begin
        int n, m;
        logic [7:0] b0, b1;
        logic [4:0] a;
        logic [7:0] d;

        vecs[0] = '{5'h18, 8'h0F, 8'hE0, 8'h0F};
        vecs[1] = '{5'h04, 8'hC1, 8'h93, 8'h01};
        vecs[2] = '{5'h1F, 8'hFF, 8'hFF, 8'h3F};
        vecs[3] = '{5'h00, 8'h00, 8'h80, 8'h00};

        RST = 1'b1; WR_VALID = 1'b0; WR_ADDR = '0; WR_DATA = '0;
        repeat (3) step();
        check("rst_ready", int'(WR_READY), 1);
        check("rst_busy",  int'(BUSY), 0);
        check("rst_sck",   int'(SPI_SCK), 0);
        check("rst_mosi",  int'(SPI_MOSI), 0);
        check("rst_cs",    int'(SPI_CS), 1);
        RST = 1'b0;
        step();

        // Directed table: bytes, start latency, and busy span from CS fall.
        foreach (vecs[i]) begin
            send(vecs[i].addr, vecs[i].data);
            n = 0;
            while (SPI_CS && n < 10) begin step(); n++; end
            check("start_latency", n, START_LAT);
            m = 0;
            while (BUSY && m < 400) begin step(); m++; end
            check("busy_len_from_cs_fall", m, TXN_LEN);
            step();
            check("tbl_rx_count", rx_q.size(), 2);
            if (rx_q.size() >= 2) begin
                b0 = rx_q.pop_front();
                b1 = rx_q.pop_front();
                check("tbl_byte0", int'(b0), int'(vecs[i].b0));
                check("tbl_byte1", int'(b1), int'(vecs[i].b1));
            end
            rx_q.delete();
        end

        // Reset after three bits of byte0, then a clean write.
        send(5'h15, 8'hAA);
        n = 0;
        while (SPI_CS && n < 10) begin step(); n++; end
        @(negedge CLK);
        n = 0;
        while (nbits < 3 && n < 200) begin step(); n++; end
        check("reached_bit3", int'(n < 200), 1);
        RST = 1'b1;
        step();
        check("midrst_cs",    int'(SPI_CS), 1);
        check("midrst_sck",   int'(SPI_SCK), 0);
        check("midrst_mosi",  int'(SPI_MOSI), 0);
        check("midrst_busy",  int'(BUSY), 0);
        check("midrst_ready", int'(WR_READY), 1);
        RST = 1'b0;
        step();
        check("midrst_no_bytes", rx_q.size(), 0);
        send(5'h0A, 8'h55);
        wait_idle(400);
        expect_write("after_rst", 5'h0A, 8'h55);

`ifdef SID_SPI_WRITER_FIFO_EN
        // Fill the FIFO while the first request is on the wire.
        rx_q.delete();
        send(5'h01, 8'h02);
        n = 0;
        while (SPI_CS && n < 10) begin step(); n++; end
        for (int k = 0; k < 4; k++) begin
            WR_VALID = 1'b1;
            WR_ADDR  = 5'(k + 3);
            WR_DATA  = 8'(8'h40 * k + 8'h11);
            check("fifo_ready_push", int'(WR_READY), 1);
            step();
        end
        check("fifo_ready_full", int'(WR_READY), 0);
        WR_VALID = 1'b0;
        wait_idle(1000);
        expect_write("fifo_first", 5'h01, 8'h02);
        for (int k = 0; k < 4; k++)
            expect_write("fifo_q", 5'(k + 3), 8'(8'h40 * k + 8'h11));
`endif

        // Random loopback: every write decodes back to its address/data, in order.
        rx_q.delete();
        for (int k = 0; k < 32; k++) begin
            a = 5'($urandom_range(0, 31));
            d = 8'($urandom_range(0, 255));
            ea.push_back(a);
            ed.push_back(d);
            send(a, d);
            repeat ($urandom_range(0, 3)) step();
        end
        wait_idle(1000);
        check("rand_rx_count", rx_q.size(), 64);
        while (ea.size() > 0 && rx_q.size() >= 2) begin
            b0 = rx_q.pop_front();
            b1 = rx_q.pop_front();
            a  = ea.pop_front();
            d  = ed.pop_front();
            check("rand_marker0", int'(b0[7]), 1);
            check("rand_addr", int'(b0[6:2]), int'(a));
            check("rand_data", int'({b0[1:0], b1[5:0]}), int'(d));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sid_spi_writer.md
# sid_spi_writer

SPI master that carries SID register writes from a local requester to the SID core's SPI slave and write decoder. Each write request (5-bit address, 8-bit data) is encoded into the two-byte wire format `1AAAAADD` then `0?DDDDDD` and shifted out MSB-first on SCK/MOSI/CS. The block sits on the host side of the link, for example in a player or bridge FPGA, and drives the same three-wire bus the SID board receives on.

## Interface
Parameters:
- `CLK_DIV`, 3: SCK half-period in CLK cycles; must be ≥1. 12 MHz / 6 = 2 MHz SCK.
- `CS_GAP`, 4: CLK cycles CS is held high between bytes; must be ≥1.

Ports:
- `CLK`  in  1  system clock.
- `RST`  in  1  reset; synchronous, active-high.
- `WR_VALID`  in  1  write request present.
- `WR_READY`  out  1  request accepted when VALID && READY at a rising CLK edge.
- `WR_ADDR`  in  5  SID register address.
- `WR_DATA`  in  8  SID register data.
- `BUSY`  out  1  high while any byte is in flight or a request is queued.
- `SPI_SCK`  out  1  SPI clock; idles low.
- `SPI_MOSI`  out  1  serial data, MSB first.
- `SPI_CS`  out  1  chip select, active low.

## Operation
- Encoding:
  - byte0 = {1, ADDR[4:0], DATA[7:6]}.
  - byte1 = {0, 0, DATA[5:0]}; bit 6 is always sent as 0.
  - byte0 is always sent before byte1. The two bytes of one request are never interleaved with another request.
- SPI mode 0:
  - MOSI changes only while SCK is low.
  - The slave samples MOSI on SCK rising.
  - CS is asserted separately for each byte.
- FSM states: IDLE, LOW, HIGH, HOLD, GAP, plus a byte-index flag.
  - IDLE: CS=1, SCK=0, MOSI=0. If a request is available, load byte0 into the shift register, set CS=0, drive MOSI=bit7, go to LOW.
  - LOW: SCK=0 for CLK_DIV cycles, then go to HIGH.
  - HIGH: SCK=1 for CLK_DIV cycles. Then:
    - if bits remain: shift, update MOSI, go to LOW;
    - after bit 0: go to HOLD.
  - HOLD: SCK=0, CS=0 for CLK_DIV cycles, then CS=1 and go to GAP.
  - GAP: CS=1 for CS_GAP cycles. Then:
    - after byte0: load byte1, CS=0, go to LOW;
    - after byte1: go to IDLE.
- Request acceptance without FIFO: WR_READY = 1 only in IDLE, with no pending request.
- BUSY = (state ≠ IDLE) or a request is queued.

## Timing
- Reset values: WR_READY=1, BUSY=0, SPI_SCK=0, SPI_MOSI=0, SPI_CS=1; FSM in IDLE; shift register = 0.
- Start latency, request accepted at edge t:
  - SPI_CS falls after edge t+1 without FIFO;
  - after edge t+2 with FIFO.
- Byte length, CS fall to CS rise: 17·CLK_DIV cycles, i.e. 51 at the default.
- Transaction length: 2·(17·CLK_DIV + CS_GAP) cycles, i.e. 110 at the default.
- Back-to-back queued requests: the next byte0's CS falls at the cycle after byte1's GAP ends; no extra IDLE cycle.
- RST asserted mid-byte: at the next edge, CS=1, SCK=0, MOSI=0, FSM goes to IDLE, and queued requests are discarded. The partial byte is abandoned; the receiver resynchronises on CS rise.
- WR_VALID held with WR_READY low: the request is not consumed. The requester must hold ADDR and DATA stable until the handshake.

## Configuration
- `SID_SPI_WRITER_FIFO_EN` defined: a 4-entry request FIFO is built in.
  - WR_READY = !full, including during transmission.
  - The FSM pops the FIFO in IDLE.
  - A push and pop in the same cycle are both honoured; occupancy is unchanged.
  - When full, WR_READY=0; a pop that cycle does not admit a push until the next cycle.
- Undefined: a single holding register, with WR_READY high only in IDLE with the register empty. Throughput is one request per transaction; no requests are buffered while a transaction is in flight.

## Test plan
- Single write, ADDR=0x18, DATA=0x0F:
  - required: byte0 = 0xE0, then byte1 = 0x0F;
  - CS low for 51 cycles per byte, high for 4 cycles between bytes;
  - BUSY high for 110 cycles.
- Write ADDR=0x04, DATA=0xC1:
  - required: bytes 0x93 then 0x01;
  - MOSI stable across every SCK rising edge;
  - SCK low whenever CS toggles.
- FIFO build:
  - push 4 requests on consecutive cycles: all accepted; WR_READY low on the 5th.
  - Required: 8 bytes emitted in order with no IDLE gap; WR_READY rises once the first pop occurs.
- Reset mid-byte:
  - assert RST after 3 bits of byte0. Required at the next edge: CS=1, SCK=0, MOSI=0, BUSY=0, WR_READY=1.
  - A following write is transmitted correctly from byte0.
- Loopback through the SID board's SPI slave and write decoder:
  - random sequence of 32 writes;
  - required: one decoder write-enable pulse per request, with matching address and data, in order.
